// File: rtl/orbit_pkg.sv
// Shared types, default sizing and helpers for the orbit integration sequencer
// and the coordinate register bank.
package orbit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_NEXT   = 3'd3,
        ST_COMMIT = 3'd4
    } orbit_state_e;

    localparam int DEF_N_PART          = 2;
    localparam int DEF_STEPS_PER_FRAME = 4;
    localparam int DEF_TIMEOUT         = 255;
    localparam int DEF_CNT_W           = 16;

    // Increment that sticks at max_value instead of wrapping (widths up to 32 bits).
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
        logic [31:0] result;
        if (value >= max_value) begin
            result = max_value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/orbit_sat_counter.sv
// Saturating event counter: counts inc_i pulses and holds at all-ones.
module orbit_sat_counter
    import orbit_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             srst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] ALL_ONES = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: soft clear wins, otherwise saturating increment on request.
    always_comb begin
        count_d = count_q;
        if (srst_i) begin
            count_d = {CNT_W{1'b0}};
        end else if (inc_i) begin
            count_d = CNT_W'(sat_inc(32'(count_q), 32'(ALL_ONES)));
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/orbit_step_scheduler.sv
// Frame-driven sequencer: on each accepted frame tick, runs STEPS_PER_FRAME
// substeps, each launching the shared integrator once per particle slot, then
// pulses commit so the coordinate bank latches a consistent frame.
module orbit_step_scheduler
    import orbit_pkg::*;
#(
    parameter int N_PART          = DEF_N_PART,
    parameter int STEPS_PER_FRAME = DEF_STEPS_PER_FRAME,
    parameter int TIMEOUT         = DEF_TIMEOUT,
    parameter int CNT_W           = DEF_CNT_W,
    localparam int IDX_W          = (N_PART > 1) ? $clog2(N_PART) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             frame_tick,
    output logic             upd_start,
    output logic [IDX_W-1:0] upd_idx,
    input  logic             upd_done,
    output logic             commit,
    output logic             busy,
    output logic [7:0]       substep,
    output logic [CNT_W-1:0] overrun_cnt,
    output logic [CNT_W-1:0] timeout_cnt
);

    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_PART - 1);
    localparam logic [7:0]       STEP_LAST = 8'(STEPS_PER_FRAME - 1);
    localparam logic [15:0]      WAIT_LAST = 16'(TIMEOUT - 1);

    orbit_state_e     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       sub_q, sub_d;
    logic [15:0]      wait_q, wait_d;
    logic             start_q, start_d;
    logic             commit_q, commit_d;
    logic             busy_q, busy_d;
    logic             overrun_inc_s;
    logic             timeout_inc_s;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a done in the final wait cycle beats the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_tick && enable) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (upd_done || (wait_q == WAIT_LAST)) begin
                    state_d = ST_NEXT;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_NEXT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if ((idx_q < IDX_LAST) || (sub_q < STEP_LAST)) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Slot/substep/wait counters and registered strobes derived from the transition.
    always_comb begin
        idx_d         = idx_q;
        sub_d         = sub_q;
        wait_d        = wait_q;
        timeout_inc_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                idx_d  = {IDX_W{1'b0}};
                sub_d  = 8'd0;
                wait_d = 16'd0;
            end
            ST_ISSUE: wait_d = 16'd0;
            ST_WAIT: begin
                if (upd_done) begin
                    wait_d = wait_q;
                end else if (wait_q == WAIT_LAST) begin
                    timeout_inc_s = 1'b1;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            ST_NEXT: begin
                if (!enable) begin
                    idx_d = {IDX_W{1'b0}};
                    sub_d = 8'd0;
                end else if (idx_q < IDX_LAST) begin
                    idx_d = idx_q + IDX_W'(1);
                end else begin
                    idx_d = {IDX_W{1'b0}};
                    if (sub_q < STEP_LAST) begin
                        sub_d = sub_q + 8'd1;
                    end else begin
                        sub_d = sub_q;
                    end
                end
            end
            ST_COMMIT: begin
                idx_d = {IDX_W{1'b0}};
                sub_d = 8'd0;
            end
            default: begin
                idx_d  = {IDX_W{1'b0}};
                sub_d  = 8'd0;
                wait_d = 16'd0;
            end
        endcase
        start_d       = (state_d == ST_ISSUE);
        commit_d      = (state_d == ST_COMMIT);
        busy_d        = (state_d != ST_IDLE);
        overrun_inc_s = frame_tick && (state_q != ST_IDLE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q    <= {IDX_W{1'b0}};
            sub_q    <= 8'd0;
            wait_q   <= 16'd0;
            start_q  <= 1'b0;
            commit_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            sub_q    <= sub_d;
            wait_q   <= wait_d;
            start_q  <= start_d;
            commit_q <= commit_d;
            busy_q   <= busy_d;
        end
    end

    orbit_sat_counter #(.CNT_W(CNT_W)) u_overrun_cnt (
        .clk     (clk),
        .rst_n   (reset_n),
        .srst_i  (1'b0),
        .inc_i   (overrun_inc_s),
        .count_o (overrun_cnt)
    );

    orbit_sat_counter #(.CNT_W(CNT_W)) u_timeout_cnt (
        .clk     (clk),
        .rst_n   (reset_n),
        .srst_i  (1'b0),
        .inc_i   (timeout_inc_s),
        .count_o (timeout_cnt)
    );

    assign upd_start = start_q;
    assign upd_idx   = idx_q;
    assign commit    = commit_q;
    assign busy      = busy_q;
    assign substep   = sub_q;

endmodule

// File: tb/tb_orbit_step_scheduler.sv
// Bench for orbit_step_scheduler: a 2-slot/4-substep instance driven by frames
// with random integrator latencies and random extra ticks, plus a 1-slot/1-step
// instance with 4-bit counters for the boundary and saturation cases.
module tb_orbit_step_scheduler;

    localparam int NA = 2;
    localparam int SA = 4;
    localparam int TO_A = 8;
    localparam int NSLOT_A = NA * SA;
    localparam int TO_B = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        frame_tick;
    logic        upd_done;
    logic        upd_start;
    logic [0:0]  upd_idx;
    logic        commit;
    logic        busy;
    logic [7:0]  substep;
    logic [15:0] overrun_cnt;
    logic [15:0] timeout_cnt;

    logic        b_tick;
    logic        b_done;
    logic        b_upd_start;
    logic [0:0]  b_upd_idx;
    logic        b_commit;
    logic        b_busy;
    logic [7:0]  b_substep;
    logic [3:0]  b_overrun_cnt;
    logic [3:0]  b_timeout_cnt;

    int total = 0;
    int bad = 0;
    int ov_exp = 0;
    int to_exp = 0;
    int b_ov_exp = 0;
    int b_to_exp = 0;
    int lat[NSLOT_A];

    always #5 clk = ~clk;

    orbit_step_scheduler #(.N_PART(NA), .STEPS_PER_FRAME(SA), .TIMEOUT(TO_A), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .frame_tick(frame_tick),
        .upd_start(upd_start), .upd_idx(upd_idx), .upd_done(upd_done), .commit(commit),
        .busy(busy), .substep(substep), .overrun_cnt(overrun_cnt), .timeout_cnt(timeout_cnt)
    );

    orbit_step_scheduler #(.N_PART(1), .STEPS_PER_FRAME(1), .TIMEOUT(TO_B), .CNT_W(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .enable(enable), .frame_tick(b_tick),
        .upd_start(b_upd_start), .upd_idx(b_upd_idx), .upd_done(b_done), .commit(b_commit),
        .busy(b_busy), .substep(b_substep), .overrun_cnt(b_overrun_cnt), .timeout_cnt(b_timeout_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame on the main instance. Entered just after a clock edge with the
    // DUT idle; cycle 0 carries the accepted tick. The schedule comes from the
    // slot rule: a slot started at s finishes its NEXT at s+min(lat,TO)+1, the
    // next start follows one cycle later, and commit follows the last NEXT.
    task automatic run_frame(input int fixed_tick, input int n_rand, input bit tick_commit);
        int st[NSLOT_A];
        bit tick_at[160];
        bit done_at[160];
        int cc;
        int e;
        int d;
        int lim;
        int ks;
        for (int c = 0; c < 160; c++) begin
            tick_at[c] = 1'b0;
            done_at[c] = 1'b0;
        end
        st[0] = 1;
        cc = 0;
        for (int k = 0; k < NSLOT_A; k++) begin
            e = (lat[k] > TO_A) ? TO_A : lat[k];
            if (k < NSLOT_A - 1) st[k+1] = st[k] + e + 2;
            else cc = st[k] + e + 2;
            if (lat[k] > TO_A) to_exp++;
        end
        // Integrator answers lat cycles after its start unless relaunched first.
        for (int k = 0; k < NSLOT_A; k++) begin
            d = st[k] + lat[k];
            lim = (k < NSLOT_A - 1) ? st[k+1] : cc + 1;
            if (d <= lim) done_at[d] = 1'b1;
        end
        tick_at[0] = 1'b1;
        if (fixed_tick > 0) tick_at[fixed_tick] = 1'b1;
        for (int i = 0; i < n_rand; i++) tick_at[$urandom_range(cc, 2)] = 1'b1;
        if (tick_commit) tick_at[cc] = 1'b1;
        for (int c = 1; c <= cc; c++) if (tick_at[c]) ov_exp++;

        for (int c = 0; c <= cc + 1; c++) begin
            if (c > 0) begin
                ks = -1;
                for (int k = 0; k < NSLOT_A; k++) if (st[k] == c) ks = k;
                chk("a_start", 32'(upd_start), 32'(ks >= 0));
                if (ks >= 0) begin
                    chk("a_idx", 32'(upd_idx), 32'(ks % NA));
                    chk("a_substep", 32'(substep), 32'(ks / NA));
                end
                chk("a_commit", 32'(commit), 32'(c == cc));
                chk("a_busy", 32'(busy), 32'(c <= cc));
            end
            frame_tick = tick_at[c];
            upd_done = done_at[c];
            @(posedge clk); #1;
        end
        frame_tick = 1'b0;
        upd_done = 1'b0;
        chk("a_idle_idx", 32'(upd_idx), 32'd0);
        chk("a_idle_substep", 32'(substep), 32'd0);
        chk("a_overrun", 32'(overrun_cnt), 32'(ov_exp));
        chk("a_timeout", 32'(timeout_cnt), 32'(to_exp));
    endtask

    // One frame on the 1-slot instance; optionally ticks every busy cycle.
    task automatic run_b(input int lat_v, input bit flood);
        int cc;
        cc = 1 + ((lat_v > TO_B) ? TO_B : lat_v) + 2;
        for (int c = 0; c <= cc + 1; c++) begin
            if (c > 0) begin
                chk("b_start", 32'(b_upd_start), 32'(c == 1));
                if (c == 1) chk("b_idx", 32'(b_upd_idx), 32'd0);
                chk("b_commit", 32'(b_commit), 32'(c == cc));
                chk("b_busy", 32'(b_busy), 32'(c <= cc));
            end
            b_tick = (c == 0) || (flood && c <= cc) || (c == cc);
            b_done = (c == 1 + lat_v);
            if (c >= 1 && c <= cc && b_tick) b_ov_exp = (b_ov_exp >= 15) ? 15 : b_ov_exp + 1;
            @(posedge clk); #1;
        end
        b_tick = 1'b0;
        b_done = 1'b0;
        if (lat_v > TO_B) b_to_exp = (b_to_exp >= 15) ? 15 : b_to_exp + 1;
        chk("b_substep", 32'(b_substep), 32'd0);
        chk("b_overrun", 32'(b_overrun_cnt), 32'(b_ov_exp));
        chk("b_timeout", 32'(b_timeout_cnt), 32'(b_to_exp));
    endtask

    initial begin
        reset_n = 1'b0;
        enable = 1'b1;
        frame_tick = 1'b0;
        upd_done = 1'b0;
        b_tick = 1'b0;
        b_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_start", 32'(upd_start), 32'd0);
        chk("rst_commit", 32'(commit), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_idx", 32'(upd_idx), 32'd0);
        chk("rst_substep", 32'(substep), 32'd0);
        chk("rst_overrun", 32'(overrun_cnt), 32'd0);
        chk("rst_timeout", 32'(timeout_cnt), 32'd0);
        chk("rst_b_busy", 32'(b_busy), 32'd0);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;

        // Nominal frame, latency 3, second tick 10 cycles in.
        for (int k = 0; k < NSLOT_A; k++) lat[k] = 3;
        run_frame(10, 0, 1'b0);

        // Slot 1 never answers: four aborts, commit still issued.
        for (int k = 0; k < NSLOT_A; k++) lat[k] = (k % 2 == 1) ? 1000 : 3;
        run_frame(0, 0, 1'b0);

        // Done on the timeout cycle, in NEXT, in ISSUE; tick on commit cycle.
        lat[0] = TO_A; lat[1] = TO_A + 1; lat[2] = TO_A + 2; lat[3] = 1;
        lat[4] = TO_A; lat[5] = TO_A - 1; lat[6] = TO_A + 3; lat[7] = TO_A + 1;
        run_frame(0, 0, 1'b1);

        // Random latencies and random overlapping ticks.
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < NSLOT_A; k++) lat[k] = $urandom_range(11, 1);
            run_frame(0, 3, 1'($urandom_range(1, 0)));
        end

        // Disable during the third WAIT: abandon at NEXT, no commit.
        for (int c = 0; c <= 20; c++) begin
            if (c > 0) begin
                chk("dis_commit", 32'(commit), 32'd0);
                chk("dis_busy", 32'(busy), 32'(c <= 15));
                chk("dis_start", 32'(upd_start), 32'(c == 1 || c == 6 || c == 11));
                if (c == 11) chk("dis_substep3", 32'(substep), 32'd1);
                if (c == 16) begin
                    chk("dis_substep", 32'(substep), 32'd0);
                    chk("dis_idx", 32'(upd_idx), 32'd0);
                end
            end
            frame_tick = (c == 0) || (c == 18);
            upd_done = (c == 4) || (c == 9) || (c == 14);
            enable = !(c >= 12 && c <= 19);
            @(posedge clk); #1;
        end
        frame_tick = 1'b0;
        upd_done = 1'b0;
        enable = 1'b1;
        chk("dis_overrun", 32'(overrun_cnt), 32'(ov_exp));
        for (int k = 0; k < NSLOT_A; k++) lat[k] = 3;
        run_frame(0, 0, 1'b0);

        // Asynchronous reset in the middle of a WAIT.
        for (int c = 0; c <= 3; c++) begin
            frame_tick = (c == 0);
            if (c < 3) begin
                @(posedge clk); #1;
            end
        end
        frame_tick = 1'b0;
        chk("ar_busy_before", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_start", 32'(upd_start), 32'd0);
        chk("ar_commit", 32'(commit), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_idx", 32'(upd_idx), 32'd0);
        chk("ar_substep", 32'(substep), 32'd0);
        chk("ar_overrun", 32'(overrun_cnt), 32'd0);
        chk("ar_timeout", 32'(timeout_cnt), 32'd0);
        @(posedge clk); #1;
        chk("ar_commit_held", 32'(commit), 32'd0);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        ov_exp = 0;
        to_exp = 0;
        run_frame(0, 0, 1'b0);

        // Single slot, single step: commit 6 cycles after accept, tick on commit counted.
        run_b(3, 1'b0);
        // Never-answering integrator with a tick every busy cycle saturates overrun.
        run_b(1000, 1'b1);
        run_b(1000, 1'b1);
        chk("b_overrun_sat", 32'(b_overrun_cnt), 32'hF);
        run_b(1000, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
